gen1_8b10b_encode: RTL and testbench

Gen1/Gen2 transmit 8b/10b encoder. It sits directly downstream of the Gen1 scrambler and consumes its scrambled data/K output, up to 4 bytes per clock. Each byte becomes a 10-bit symbol, with running disparity (RD) chained across active lanes and carried from cycle to cycle. The encoded word feeds the PIPE TX serializer interface.

---
 rtl/gen1_8b10b_encode.sv | 216 +++++++++++++++++++++
 tb/tb_gen1_8b10b_encode.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gen1_8b10b_encode.sv
// Gen1/Gen2 transmit 8b/10b encoder: up to four bytes per clock with running
// disparity chained lane 0 -> lane N-1 and carried between valid words.
module gen1_8b10b_encode (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_in_i,
    input  logic [3:0]  data_k_in_i,
    input  logic        data_valid_i,
    input  logic [5:0]  pipe_width_i,
    input  logic        rd_force_neg_i,
    output logic [39:0] data_out_o,
    output logic        data_valid_o,
    output logic [3:0]  code_err_o,
    output logic        rd_o
);

    typedef struct packed {
        logic [9:0] sym;
        logic       rd;
        logic       err;
    } enc_t;

    function automatic logic [2:0] ones6(input logic [5:0] v);
        ones6 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} +
                {2'b00, v[3]} + {2'b00, v[4]} + {2'b00, v[5]};
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] v);
        ones4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // 5b/6b data codes at RD-, written abcdei with a in the MSB.
    function automatic logic [5:0] d6_neg(input logic [4:0] x);
        case (x)
            5'd0:    d6_neg = 6'b100111;
            5'd1:    d6_neg = 6'b011101;
            5'd2:    d6_neg = 6'b101101;
            5'd3:    d6_neg = 6'b110001;
            5'd4:    d6_neg = 6'b110101;
            5'd5:    d6_neg = 6'b101001;
            5'd6:    d6_neg = 6'b011001;
            5'd7:    d6_neg = 6'b111000;
            5'd8:    d6_neg = 6'b111001;
            5'd9:    d6_neg = 6'b100101;
            5'd10:   d6_neg = 6'b010101;
            5'd11:   d6_neg = 6'b110100;
            5'd12:   d6_neg = 6'b001101;
            5'd13:   d6_neg = 6'b101100;
            5'd14:   d6_neg = 6'b011100;
            5'd15:   d6_neg = 6'b010111;
            5'd16:   d6_neg = 6'b011011;
            5'd17:   d6_neg = 6'b100011;
            5'd18:   d6_neg = 6'b010011;
            5'd19:   d6_neg = 6'b110010;
            5'd20:   d6_neg = 6'b001011;
            5'd21:   d6_neg = 6'b101010;
            5'd22:   d6_neg = 6'b011010;
            5'd23:   d6_neg = 6'b111010;
            5'd24:   d6_neg = 6'b110011;
            5'd25:   d6_neg = 6'b100110;
            5'd26:   d6_neg = 6'b010110;
            5'd27:   d6_neg = 6'b110110;
            5'd28:   d6_neg = 6'b001110;
            5'd29:   d6_neg = 6'b101110;
            5'd30:   d6_neg = 6'b011110;
            5'd31:   d6_neg = 6'b101011;
            default: d6_neg = 6'b000000;
        endcase
    endfunction

    // 3b/4b data codes at RD- (fghj); y=7 returns the primary P7 form.
    function automatic logic [3:0] d4_neg(input logic [2:0] y);
        case (y)
            3'd0:    d4_neg = 4'b1011;
            3'd1:    d4_neg = 4'b1001;
            3'd2:    d4_neg = 4'b0101;
            3'd3:    d4_neg = 4'b1100;
            3'd4:    d4_neg = 4'b1101;
            3'd5:    d4_neg = 4'b1010;
            3'd6:    d4_neg = 4'b0110;
            3'd7:    d4_neg = 4'b1110;
            default: d4_neg = 4'b0000;
        endcase
    endfunction

    // 3b/4b control codes at RD-; y=1/5/6 are the comma alternates.
    function automatic logic [3:0] k4_neg(input logic [2:0] y);
        case (y)
            3'd0:    k4_neg = 4'b1011;
            3'd1:    k4_neg = 4'b0110;
            3'd2:    k4_neg = 4'b1010;
            3'd3:    k4_neg = 4'b1100;
            3'd4:    k4_neg = 4'b1101;
            3'd5:    k4_neg = 4'b0101;
            3'd6:    k4_neg = 4'b1001;
            3'd7:    k4_neg = 4'b0111;
            default: k4_neg = 4'b0000;
        endcase
    endfunction

    // A7 avoids a run of five identical bits across the 6b/4b boundary.
    function automatic logic use_a7(input logic [4:0] x, input logic rd);
        if (rd) begin
            use_a7 = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        end else begin
            use_a7 = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        end
    endfunction

    function automatic logic k_legal(input logic [7:0] b);
        k_legal = (b[4:0] == 5'd28) ||
                  ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                        (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
    endfunction

    function automatic enc_t enc_byte(input logic [7:0] b, input logic k, input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic       is_k;
        logic       rd_mid;
        logic [5:0] s6;
        logic [3:0] s4;
        logic [9:0] str;
        enc_t       r;
        x    = b[4:0];
        y    = b[7:5];
        is_k = k && k_legal(b);
        if (is_k && (x == 5'd28)) begin
            s6 = 6'b001111;
        end else begin
            s6 = d6_neg(x);
        end
        // D.7 is balanced but still has a distinct RD+ form.
        if (rd_in && ((ones6(s6) != 3'd3) || (!is_k && (x == 5'd7)))) begin
            s6 = ~s6;
        end else begin
            s6 = s6;
        end
        rd_mid = (ones6(s6) != 3'd3) ? ~rd_in : rd_in;
        if (is_k) begin
            s4 = rd_mid ? ~k4_neg(y) : k4_neg(y);
        end else if ((y == 3'd7) && use_a7(x, rd_mid)) begin
            s4 = rd_mid ? 4'b1000 : 4'b0111;
        end else if (rd_mid && ((ones4(d4_neg(y)) != 3'd2) || (y == 3'd3))) begin
            s4 = ~d4_neg(y);
        end else begin
            s4 = d4_neg(y);
        end
        str = {s6, s4};
        for (int i = 0; i < 10; i++) begin
            r.sym[i] = str[9-i];
        end
        r.rd  = (ones4(s4) != 3'd2) ? ~rd_mid : rd_mid;
        r.err = k && !is_k;
        enc_byte = r;
    endfunction

    logic [39:0] r_data_out;
    logic [3:0]  r_code_err;
    logic        r_valid;
    logic        r_rd;

    logic [3:0]  w_active;
    logic [4:0]  w_rd_chain;
    logic [39:0] w_data;
    logic [3:0]  w_err;
    enc_t        w_enc [4];

    // Per-lane encode with disparity rippling through the active lanes.
    always_comb begin
        case (pipe_width_i)
            6'd16:   w_active = 4'b0011;
            6'd32:   w_active = 4'b1111;
            default: w_active = 4'b0001;
        endcase
        w_data        = 40'd0;
        w_err         = 4'b0000;
        w_rd_chain    = 5'b00000;
        w_rd_chain[0] = rd_force_neg_i ? 1'b0 : r_rd;
        for (int n = 0; n < 4; n++) begin
            w_enc[n] = enc_byte(data_in_i[8*n +: 8], data_k_in_i[n], w_rd_chain[n]);
            if (w_active[n]) begin
                w_data[10*n +: 10] = w_enc[n].sym;
                w_err[n]           = w_enc[n].err;
                w_rd_chain[n+1]    = w_enc[n].rd;
            end else begin
                w_data[10*n +: 10] = 10'd0;
                w_err[n]           = 1'b0;
                w_rd_chain[n+1]    = w_rd_chain[n];
            end
        end
    end

    // Output and running-disparity registers; idle words leave them untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data_out <= 40'd0;
            r_code_err <= 4'b0000;
            r_valid    <= 1'b0;
            r_rd       <= 1'b0;
        end else if (data_valid_i) begin
            r_data_out <= w_data;
            r_code_err <= w_err;
            r_valid    <= 1'b1;
            r_rd       <= w_rd_chain[4];
        end else begin
            r_valid    <= 1'b0;
        end
    end

    assign data_out_o   = r_data_out;
    assign code_err_o   = r_code_err;
    assign data_valid_o = r_valid;
    assign rd_o         = r_rd;

endmodule

// File: tb/tb_gen1_8b10b_encode.sv
// Vector table plus a multi-width K28.5 stream, checked through an expectation queue.
module tb_gen1_8b10b_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [3:0]  kin;
    logic        vin;
    logic [5:0]  width;
    logic        force_neg;
    logic [39:0] dout;
    logic        vout;
    logic [3:0]  err;
    logic        rd;

    gen1_8b10b_encode dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_in_i      (din),
        .data_k_in_i    (kin),
        .data_valid_i   (vin),
        .pipe_width_i   (width),
        .rd_force_neg_i (force_neg),
        .data_out_o     (dout),
        .data_valid_o   (vout),
        .code_err_o     (err),
        .rd_o           (rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [5:0]  w;
        logic        frc;
        logic [31:0] d;
        logic [3:0]  k;
        logic [9:0]  l0, l1, l2, l3;
        logic [3:0]  err;
        logic        ev;
        logic        rd;
    } vec_t;

    typedef struct {
        int          tag;
        logic [39:0] out;
        logic [3:0]  err;
        logic        ev;
        logic        rd;
    } exp_t;

    localparam logic [9:0] KN = 10'b0011111010;
    localparam logic [9:0] KP = 10'b1100000101;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Symbols are written abcdeifghj; bit a is transmitted first (bit 0).
    function automatic logic [9:0] rev10(input logic [9:0] s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = s[9-i];
        return r;
    endfunction

    function automatic logic [39:0] pack4(input logic [9:0] a, b, c, d);
        return {rev10(d), rev10(c), rev10(b), rev10(a)};
    endfunction

    task automatic cmp(input string nm, input int tag, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %h want %h", nm, tag, act, exp);
        end
    endtask

    task automatic apply(input int tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; vin = v.vld; width = v.w; force_neg = v.frc; din = v.d; kin = v.k;
        e.tag = tag; e.out = pack4(v.l0, v.l1, v.l2, v.l3);
        e.err = v.err; e.ev = v.ev; e.rd = v.rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard (step %0d): got empty want entry", tag);
        end else begin
            e = sb.pop_front();
            cmp("data_out", e.tag, dout, e.out);
            cmp("code_err", e.tag, {36'd0, err}, {36'd0, e.err});
            cmp("valid", e.tag, {39'd0, vout}, {39'd0, e.ev});
            cmp("rd", e.tag, {39'd0, rd}, {39'd0, e.rd});
        end
    endtask

    initial begin
        vec_t v;
        logic rd_m;
        rst = 1'b1; vin = 1'b0; width = 6'd8; force_neg = 1'b0; din = 32'd0; kin = 4'd0;

        //            rst   vld   w      frc   data          k        l0            l1            l2            l3            err      ev    rd
        vecs.push_back('{1'b1, 1'b0, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, 10'd0,        10'd0,        10'd0,        10'd0,        4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, KN,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, KP,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6'd32, 1'b0, 32'h4AB5_00BC, 4'b0001, KN,           10'b0110001011, 10'b1010101010, 10'b0101010101, 4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b1, 32'h0000_00F1, 4'b0000, 10'b1000110111, 10'd0,      10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00EB, 4'b0000, 10'b1101001000, 10'd0,      10'd0,        10'd0,        4'b0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00EB, 4'b0000, 10'b1101001110, 10'd0,      10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00F1, 4'b0000, 10'b1000110001, 10'd0,      10'd0,        10'd0,        4'b0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6'd16, 1'b0, 32'hFFFF_BC00, 4'b1111, 10'b1001110100, KN,         10'd0,        10'd0,        4'b0001, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, KP,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, KN,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 6'd32, 1'b1, 32'h1234_5678, 4'b1010, KN,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 6'd16, 1'b0, 32'hBCBC_BCBC, 4'b1111, KN,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 6'd8,  1'b1, 32'h0000_0000, 4'b0001, KN,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, KP,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, KN,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b1, 32'h0000_00BC, 4'b0001, KN,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd24, 1'b0, 32'hBCBC_BC00, 4'b1110, 10'b0110001011, 10'd0,      10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, 10'd0,        10'd0,        10'd0,        10'd0,        4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_00BC, 4'b0001, KN,           10'd0,        10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd32, 1'b0, 32'hFE15_1CF7, 4'b1111, 10'b0001010111, 10'b1100001011, 10'b1010100100, 10'b0111101000, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 6'd16, 1'b0, 32'h0000_FC3C, 4'b0011, 10'b0011111001, 10'b1100000111, 10'd0,      10'd0,        4'b0000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 6'd8,  1'b0, 32'h0000_0067, 4'b0000, 10'b0001110011, 10'd0,      10'd0,        10'd0,        4'b0000, 1'b1, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // K28.5 on every lane while the width cycles 8/16/32; RD model ripples per lane.
        rd_m = 1'b1;
        for (int c = 0; c < 6; c++) begin
            logic [9:0] l [4];
            int         nl;
            nl = (c % 3 == 0) ? 1 : ((c % 3 == 1) ? 2 : 4);
            for (int n = 0; n < 4; n++) begin
                if (n < nl) begin
                    l[n] = rd_m ? KP : KN;
                    rd_m = ~rd_m;
                end else begin
                    l[n] = 10'd0;
                end
            end
            v = '{1'b0, 1'b1, (nl == 1) ? 6'd8 : ((nl == 2) ? 6'd16 : 6'd32), 1'b0,
                  32'hBCBC_BCBC, 4'b1111, l[0], l[1], l[2], l[3], 4'b0000, 1'b1, rd_m};
            apply(100 + c, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
